tnn_popcount_neuron_seq: RTL and testbench
==========================================

Name: tnn_popcount_neuron_seq

Overview:
- Sequencer for one ternary neuron built around a single shared 14-input (approximate) popcount unit. The popcount unit is external and combinational: 14-bit input, 4-bit count out.
- Streams an input activation vector in 14-bit chunks and time-multiplexes the popcount between the positive-weight phase and the negative-weight phase.
- Accumulates the signed difference and emits a ternary activation through a valid/ready handshake.
- Sits between the layer input buffer and the layer output collector.

Parameters:
N_CHUNKS, 4, number of 14-bit chunks per neuron evaluation (≥1)
CNT_W, 4, width of popcount result from the shared unit
ACC_W, 8, signed accumulator/threshold width; must be ≥ CNT_W+clog2(N_CHUNKS)+1

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  chunk valid
in_ready  out  1  chunk accepted when in_valid&in_ready at clk edge
in_x  in  14  binary activation chunk
in_wp  in  14  positive-weight mask
in_wn  in  14  negative-weight mask
thr_hi  in  ACC_W  signed upper threshold
thr_lo  in  ACC_W  signed lower threshold
pc_a  out  14  operand driven to shared popcount unit
pc_cnt  in  CNT_W  popcount result, combinational from pc_a, same cycle
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_sum  out  ACC_W  signed sum of pos_count − neg_count
out_act  out  2  ternary activation: 2'b01=+1, 2'b00=0, 2'b11=−1

Behaviour:
- Reset (synchronous, active-high) sets:
  - state=IDLE, acc=0, chunk_cnt=0.
  - out_valid=0, out_sum=0, out_act=00.
  - Chunk and threshold registers cleared.
  - Reset applies from any state; an in-flight evaluation is discarded with no partial output.
- States: IDLE, WAIT, POS, NEG, OUT.
- in_ready is 1 in IDLE and WAIT, and in NEG when chunk_cnt≠N_CHUNKS−1. Otherwise it is 0.
- pc_a is (x_r & wp_r) in POS and (x_r & wn_r) in NEG. It is 0 in all other states.
- IDLE:
  - On accept: latch x/wp/wn, latch thr_hi/thr_lo, set acc=0, chunk_cnt=0, go to POS.
- WAIT:
  - On accept: latch x/wp/wn, go to POS. acc is held.
- POS:
  - acc ← sat(acc + pc_cnt), zero-extended. Go to NEG. Always exactly one cycle.
- NEG, with acc' = sat(acc − pc_cnt):
  - If chunk_cnt==N_CHUNKS−1: go to OUT. Register out_sum=acc', out_act=f(acc'), out_valid=1.
  - Else: chunk_cnt++. If a chunk is accepted this same cycle, latch it and go to POS (back-to-back, 2 cycles/chunk). Otherwise go to WAIT.
- OUT:
  - out_valid stays high; out_sum and out_act stay stable until out_ready.
  - On out_valid&out_ready: out_valid=0 next cycle, go to IDLE.
  - out_sum/out_act keep their last value after handshake.
- Activation function f(s), signed compare against the latched thresholds:
  - s > thr_hi → +1.
  - else s < thr_lo → −1.
  - else → 0.
  - If thr_lo > thr_hi, the +1 test takes priority.
- Saturation: acc clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. No wrap-around.
- Latency: first chunk accepted at edge E0 with back-to-back chunks → out_valid visible after edge E(2·N_CHUNKS). This is edge E8 for the default.
- in_valid while in_ready=0 is ignored; the source must hold its data until accepted.
- Thresholds changing mid-evaluation have no effect.
- N_CHUNKS=1: the path is IDLE→POS→NEG→OUT.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → out_valid=0, out_sum=0, out_act=00, pc_a=0. in_ready=1 in the first cycle after release.
- Back-to-back all-positive: 4 chunks, x=3FFF, wp=3FFF, wn=0, thr_hi=10, thr_lo=−10, exact popcount model, in_valid held → pc_a alternates 3FFF/0000, in_ready pulses in each NEG, out_valid after E8, out_sum=56, out_act=01.
- Gapped negative input: same stream with wp=0, wn=3FFF and 3 idle cycles between chunks → WAIT entered each gap, pc_a=0 in WAIT, out_sum=−56, out_act=11.
- Dead-zone and thresholds: x=00FF, wp=000F, wn=00F0 for all chunks → out_sum=0, out_act=00. Same stimulus with thr_hi=−1 → 01. thr_lo=1 with thr_hi=5 → 11.
- Backpressure: out_ready=0 for 5 cycles in OUT while in_valid=1 → in_ready=0, outputs stable for all 5 cycles. out_ready=1 → IDLE, and the next vector is accepted the cycle after.
- Reset mid-operation and saturation:
  - rst during NEG of chunk 2 → IDLE, acc=0, no out_valid. The next full vector gives the correct sum.
  - ACC_W=6, N_CHUNKS=4, popcount stub forced to 15, wn=0 → out_sum=31, saturated.

Source files
------------

// File: rtl/tnn_popcount_neuron_seq.sv
// ============================================================================
// Module   : tnn_popcount_neuron_seq
// Function : Ternary-neuron sequencer that time-multiplexes one shared
//            popcount unit between the positive and negative weight phases.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tnn_popcount_neuron_seq #(
    parameter int N_CHUNKS = 4,
    parameter int CNT_W    = 4,
    parameter int ACC_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [13:0]             in_x,
    input  logic [13:0]             in_wp,
    input  logic [13:0]             in_wn,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic [13:0]             pc_a,
    input  logic [CNT_W-1:0]        pc_cnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [1:0]              out_act
);

    localparam int                      C_CC_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [C_CC_W-1:0]       C_LAST = C_CC_W'(N_CHUNKS - 1);
    localparam logic signed [ACC_W-1:0] C_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_POS  = 3'd2,
        S_NEG  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [C_CC_W-1:0]         r_chunk_cnt;
    logic [13:0]               r_x;
    logic [13:0]               r_wp;
    logic [13:0]               r_wn;
    logic signed [ACC_W-1:0]   r_thr_hi;
    logic signed [ACC_W-1:0]   r_thr_lo;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_out_sum;
    logic [1:0]                r_out_act;

    logic                      w_last;
    logic                      w_accept;
    logic [ACC_W:0]            w_acc_ext;
    logic [ACC_W:0]            w_cnt_ext;
    logic signed [ACC_W-1:0]   w_add_sat;
    logic signed [ACC_W-1:0]   w_sub_sat;
    logic [1:0]                w_act;

    // One extra bit of headroom: overflow shows as disagreement of the top two bits.
    function automatic logic signed [ACC_W-1:0] f_sat(input logic [ACC_W:0] v);
        if (v[ACC_W] != v[ACC_W-1])
            return v[ACC_W] ? C_MIN : C_MAX;
        else
            return v[ACC_W-1:0];
    endfunction

    assign w_last    = (r_chunk_cnt == C_LAST);
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_cnt_ext = {{(ACC_W+1-CNT_W){1'b0}}, pc_cnt};
    assign w_add_sat = f_sat(w_acc_ext + w_cnt_ext);
    assign w_sub_sat = f_sat(w_acc_ext - w_cnt_ext);

    always_comb begin
        in_ready = 1'b0;
        pc_a     = 14'd0;
        case (r_state)
            S_IDLE, S_WAIT: in_ready = 1'b1;
            S_POS:          pc_a     = r_x & r_wp;
            S_NEG: begin
                pc_a     = r_x & r_wn;
                in_ready = ~w_last;
            end
            default: ;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // The +1 test is evaluated first so it wins when thr_lo > thr_hi.
    always_comb begin
        w_act = 2'b00;
        if (w_sub_sat > r_thr_hi)
            w_act = 2'b01;
        else if (w_sub_sat < r_thr_lo)
            w_act = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_chunk_cnt <= '0;
            r_x         <= '0;
            r_wp        <= '0;
            r_wn        <= '0;
            r_thr_hi    <= '0;
            r_thr_lo    <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_act   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x         <= in_x;
                        r_wp        <= in_wp;
                        r_wn        <= in_wn;
                        r_thr_hi    <= thr_hi;
                        r_thr_lo    <= thr_lo;
                        r_acc       <= '0;
                        r_chunk_cnt <= '0;
                        r_state     <= S_POS;
                    end
                end
                S_WAIT: begin
                    if (w_accept) begin
                        r_x     <= in_x;
                        r_wp    <= in_wp;
                        r_wn    <= in_wn;
                        r_state <= S_POS;
                    end
                end
                S_POS: begin
                    r_acc   <= w_add_sat;
                    r_state <= S_NEG;
                end
                S_NEG: begin
                    r_acc <= w_sub_sat;
                    if (w_last) begin
                        r_out_sum   <= w_sub_sat;
                        r_out_act   <= w_act;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_chunk_cnt <= r_chunk_cnt + 1'b1;
                        if (w_accept) begin
                            r_x     <= in_x;
                            r_wp    <= in_wp;
                            r_wn    <= in_wn;
                            r_state <= S_POS;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_act   = r_out_act;

endmodule

`default_nettype wire

// File: tb/tb_tnn_popcount_neuron_seq.sv
// ============================================================================
// Module   : tb_tnn_popcount_neuron_seq
// Function : Self-checking bench; exact-popcount DUT plus a 6-bit saturating
//            DUT driven by a stub counter, both against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tnn_popcount_neuron_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [13:0] in_x, in_wp, in_wn;
    int          thr_hi_v, thr_lo_v;

    logic        in_ready1, in_ready2, out_valid1, out_valid2;
    logic [13:0] pc_a1, pc_a2;
    logic [3:0]  pc_cnt1, pc_cnt2;
    logic signed [7:0] out_sum1, thr_hi8, thr_lo8;
    logic signed [5:0] out_sum2, thr_hi6, thr_lo6;
    logic [1:0]  out_act1, out_act2;

    int tests = 0;
    int fails = 0;

    logic [13:0] vx[4], vwp[4], vwn[4];

    always #5 clk = ~clk;

    assign thr_hi8 = thr_hi_v[7:0];
    assign thr_lo8 = thr_lo_v[7:0];
    assign thr_hi6 = thr_hi_v[5:0];
    assign thr_lo6 = thr_lo_v[5:0];
    assign pc_cnt1 = 4'($countones(pc_a1));
    assign pc_cnt2 = (pc_a2 != 14'd0) ? 4'd15 : 4'd0;

    tnn_popcount_neuron_seq #(.N_CHUNKS(4), .CNT_W(4), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_x(in_x), .in_wp(in_wp), .in_wn(in_wn),
        .thr_hi(thr_hi8), .thr_lo(thr_lo8),
        .pc_a(pc_a1), .pc_cnt(pc_cnt1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_act(out_act1)
    );

    tnn_popcount_neuron_seq #(.N_CHUNKS(4), .CNT_W(4), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_x(in_x), .in_wp(in_wp), .in_wn(in_wn),
        .thr_hi(thr_hi6), .thr_lo(thr_lo6),
        .pc_a(pc_a2), .pc_cnt(pc_cnt2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_act(out_act2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: per chunk add the positive count, subtract the negative count,
    // clamping to the signed range after every step.
    function automatic void model(input int w, input bit stub, input int thi, input int tlo,
                                  output int s, output logic [1:0] a);
        int lo, hi, acc, p, n;
        lo  = -(1 << (w - 1));
        hi  = (1 << (w - 1)) - 1;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            p = stub ? (((vx[c] & vwp[c]) != 0) ? 15 : 0) : $countones(vx[c] & vwp[c]);
            n = stub ? (((vx[c] & vwn[c]) != 0) ? 15 : 0) : $countones(vx[c] & vwn[c]);
            acc = acc + p;
            if (acc > hi) acc = hi;
            acc = acc - n;
            if (acc < lo) acc = lo;
        end
        s = acc;
        a = (acc > thi) ? 2'b01 : ((acc < tlo) ? 2'b11 : 2'b00);
    endfunction

    task automatic run_vector(input int thi, input int tlo, input int gap, input int hold);
        int s8, s6, n;
        logic [1:0] a8, a6;
        model(8, 1'b0, thi, tlo, s8, a8);
        model(6, 1'b1, thi, tlo, s6, a6);
        thr_hi_v = thi;
        thr_lo_v = tlo;
        for (int i = 0; i < 4; i++) begin
            in_x = vx[i]; in_wp = vwp[i]; in_wn = vwn[i];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready1 && n < 100) begin tick(); n++; end
            if (n >= 100) chk("accept_timeout", {31'd0, in_ready1}, 32'd1);
            tick();
            if (i == 0) begin
                thr_hi_v = int'($urandom_range(0, 63)) - 32;
                thr_lo_v = int'($urandom_range(0, 63)) - 32;
            end
            chk("pos_pc_a", {18'd0, pc_a1}, {18'd0, vx[i] & vwp[i]});
            chk("pos_in_ready", {31'd0, in_ready1}, 32'd0);
            tick();
            chk("neg_pc_a", {18'd0, pc_a1}, {18'd0, vx[i] & vwn[i]});
            chk("neg_in_ready", {31'd0, in_ready1}, (i != 3) ? 32'd1 : 32'd0);
            chk("neg_no_valid", {31'd0, out_valid1}, 32'd0);
            if (i != 3 && gap > 0) begin
                in_valid = 1'b0;
                tick();
                chk("wait_pc_a", {18'd0, pc_a1}, 32'd0);
                chk("wait_in_ready", {31'd0, in_ready1}, 32'd1);
                repeat (gap - 1) tick();
            end
        end
        in_valid = 1'b1;
        in_x = 14'($urandom); in_wp = 14'($urandom); in_wn = 14'($urandom);
        tick();
        chk("out_valid8", {31'd0, out_valid1}, 32'd1);
        chk("out_valid6", {31'd0, out_valid2}, 32'd1);
        chk("out_sum8", 32'($signed(out_sum1)), 32'(s8));
        chk("out_act8", {30'd0, out_act1}, {30'd0, a8});
        chk("out_sum6", 32'($signed(out_sum2)), 32'(s6));
        chk("out_act6", {30'd0, out_act2}, {30'd0, a6});
        chk("out_in_ready", {31'd0, in_ready1}, 32'd0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid1}, 32'd1);
            chk("hold_sum", 32'($signed(out_sum1)), 32'(s8));
            chk("hold_act", {30'd0, out_act1}, {30'd0, a8});
            chk("hold_in_ready", {31'd0, in_ready1}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("post_valid", {31'd0, out_valid1}, 32'd0);
        chk("post_in_ready", {31'd0, in_ready1}, 32'd1);
        chk("post_sum_kept", 32'($signed(out_sum1)), 32'(s8));
    endtask

    task automatic fill(input logic [13:0] x, input logic [13:0] wp, input logic [13:0] wn);
        for (int i = 0; i < 4; i++) begin
            vx[i] = x; vwp[i] = wp; vwn[i] = wn;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_x = 14'h3FFF; in_wp = 14'h3FFF; in_wn = 14'h0;
        thr_hi_v = 10; thr_lo_v = -10;

        // Reset with in_valid asserted
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_out_sum", 32'($signed(out_sum1)), 32'd0);
        chk("rst_out_act", {30'd0, out_act1}, 32'd0);
        chk("rst_pc_a", {18'd0, pc_a1}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        tick();

        // All-positive back-to-back; 6-bit DUT saturates at +31
        fill(14'h3FFF, 14'h3FFF, 14'h0000);
        run_vector(10, -10, 0, 0);

        // All-negative with gaps; 6-bit DUT saturates at -32
        fill(14'h3FFF, 14'h0000, 14'h3FFF);
        run_vector(10, -10, 3, 0);

        // Dead-zone and threshold variants
        fill(14'h00FF, 14'h000F, 14'h00F0);
        run_vector(10, -10, 0, 0);
        run_vector(-1, -10, 1, 0);
        run_vector(5, 1, 0, 0);
        run_vector(-3, 3, 0, 0);

        // Backpressure in OUT
        fill(14'h1234, 14'h0F0F, 14'h30F0);
        run_vector(2, -2, 0, 5);

        // Reset in the NEG phase of chunk 2 discards the evaluation
        fill(14'h3FFF, 14'h3FFF, 14'h0000);
        in_x = vx[0]; in_wp = vwp[0]; in_wn = vwn[0]; in_valid = 1'b1;
        tick(); tick();
        in_x = vx[1]; in_wp = vwp[1]; in_wn = vwn[1];
        tick(); tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_valid", {31'd0, out_valid1}, 32'd0);
        chk("midrst_pc_a", {18'd0, pc_a1}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready1}, 32'd1);
        repeat (10) tick();
        chk("midrst_no_valid", {31'd0, out_valid1}, 32'd0);
        fill(14'h0FF0, 14'h00FF, 14'h0F00);
        run_vector(0, 0, 0, 0);

        // Randomized vectors
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                vx[i]  = 14'($urandom);
                vwp[i] = 14'($urandom);
                vwn[i] = 14'($urandom) & ~vwp[i];
            end
            run_vector(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
